// File: rtl/vx_dp_ram_sched_pkg.sv
// -----------------------------------------------------------------------------
// vx_dp_ram_sched_pkg
// Shared types and helpers for the scheduled dual-port RAM.
//   state_e : scheduler FSM states (INIT sweep, RUN serving requests)
//   log2up  : index width helper, never returns less than 1
// -----------------------------------------------------------------------------
package vx_dp_ram_sched_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int log2up(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/vx_dp_ram.sv
// -----------------------------------------------------------------------------
// vx_dp_ram
// Simple dual-port RAM: one lane-masked write port, one read port with a
// registered output. A read hitting the address being written in the same
// cycle returns the post-write word (written lanes new, others old).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset (rdata -> 0)
//   we, waddr, wren,
//   wdata               : write enable, address, lane mask, data
//   re, raddr           : read enable, address
//   rdata               : registered read data, updated only when re=1
// -----------------------------------------------------------------------------
module vx_dp_ram
    import vx_dp_ram_sched_pkg::*;
#(
    parameter  int DATAW = 32,
    parameter  int SIZE  = 64,
    parameter  int WRENW = 4,
    localparam int ADDRW = log2up(SIZE),
    localparam int LANEW = DATAW / WRENW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [WRENW-1:0] wren,
    input  logic [DATAW-1:0] wdata,
    input  logic             re,
    input  logic [ADDRW-1:0] raddr,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem [SIZE];
    logic [DATAW-1:0] fwd_data;

    // Same-cycle write forwarding, lane by lane.
    always_comb begin
        fwd_data = mem[raddr];
        for (int l = 0; l < WRENW; l++) begin
            if (we && wren[l] && (waddr == raddr)) begin
                fwd_data[l*LANEW +: LANEW] = wdata[l*LANEW +: LANEW];
            end
        end
    end

    // NOTE: the storage array has no reset; contents are defined by the
    // scheduler's INIT sweep, which keeps it mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < WRENW; l++) begin
                if (wren[l]) begin
                    mem[waddr][l*LANEW +: LANEW] <= wdata[l*LANEW +: LANEW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= fwd_data;
        end
    end

endmodule

// File: rtl/vx_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vx_rr_arbiter
// Round-robin arbiter. The requester at the priority pointer wins first, then
// the search wraps upward. After a grant the pointer moves to the slot just
// past the winner; with no grant it holds.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (pointer -> 0)
//   requests     : per-requester request vector
//   grants       : one-hot grant, combinational from requests and pointer
//   grant_idx    : index of the granted requester
//   grant_valid  : a grant was issued this cycle
// -----------------------------------------------------------------------------
module vx_rr_arbiter
    import vx_dp_ram_sched_pkg::*;
#(
    parameter  int NUM_REQS = 4,
    localparam int SELW     = log2up(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    output logic [NUM_REQS-1:0] grants,
    output logic [SELW-1:0]     grant_idx,
    output logic                grant_valid
);

    logic [SELW-1:0] ptr;

    // NOTE: every output gets a default before any conditional assignment, so
    // no path through the block leaves a value unassigned (no latch).
    always_comb begin
        grants      = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!grant_valid && requests[(int'(ptr) + i) % NUM_REQS]) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'((int'(ptr) + i) % NUM_REQS);
            end
        end
        if (grant_valid) begin
            grants[grant_idx] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= SELW'((int'(grant_idx) + 1) % NUM_REQS);
        end
    end

endmodule

// File: rtl/vx_dp_ram_sched.sv
// -----------------------------------------------------------------------------
// vx_dp_ram_sched
// A RAM shared by NUM_REQS requesters. After reset or flush the whole array is
// swept with INIT_VALUE (one word per cycle); afterwards one write and one read
// are granted per cycle by two independent round-robin arbiters. Read data
// returns one cycle after the grant, tagged with the requester index.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : restart the INIT sweep from address 0
//   req_valid, req_rw, req_addr, req_wren, req_data : packed per-requester
//                 request fields (rw: 1 = write, 0 = read)
//   req_ready   : per-requester grant, combinational
//   rsp_valid, rsp_idx, rsp_data : read response, no backpressure
//   init_done   : high while serving requests (RUN)
// -----------------------------------------------------------------------------
module vx_dp_ram_sched
    import vx_dp_ram_sched_pkg::*;
#(
    parameter  int               NUM_REQS   = 4,
    parameter  int               DATAW      = 32,
    parameter  int               SIZE       = 64,
    parameter  int               WRENW      = 4,
    parameter  logic [DATAW-1:0] INIT_VALUE = '0,
    localparam int               ADDRW      = log2up(SIZE),
    localparam int               REQ_SELW   = log2up(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS-1:0]       req_rw,
    input  logic [NUM_REQS*ADDRW-1:0] req_addr,
    input  logic [NUM_REQS*WRENW-1:0] req_wren,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      rsp_valid,
    output logic [REQ_SELW-1:0]       rsp_idx,
    output logic [DATAW-1:0]          rsp_data,
    output logic                      init_done
);

    if (DATAW % WRENW != 0) begin : g_bad_wrenw
        $error("DATAW must be a multiple of WRENW");
    end

    state_e           state, state_next;
    logic [ADDRW-1:0] init_cnt, init_cnt_next;
    logic             run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        case (state)
            ST_INIT: begin
                if (init_cnt == ADDRW'(SIZE - 1)) begin
                    state_next    = ST_RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt + 1'b1;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
        // Flush wins in either state and always restarts the sweep at 0.
        if (flush) begin
            state_next    = ST_INIT;
            init_cnt_next = '0;
        end
    end

    assign run       = (state == ST_RUN);
    assign init_done = run;

    // Arbitration: requests are masked outside RUN, so pointers only move on
    // real grants.
    logic [NUM_REQS-1:0] rd_req, wr_req, rd_grants, wr_grants;
    logic [REQ_SELW-1:0] rd_idx, wr_idx;
    logic                rd_valid, wr_valid;

    assign rd_req = req_valid & ~req_rw & {NUM_REQS{run}};
    assign wr_req = req_valid &  req_rw & {NUM_REQS{run}};

    vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_rd_arb (
        .clk         (clk),
        .reset       (reset),
        .requests    (rd_req),
        .grants      (rd_grants),
        .grant_idx   (rd_idx),
        .grant_valid (rd_valid)
    );

    vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_wr_arb (
        .clk         (clk),
        .reset       (reset),
        .requests    (wr_req),
        .grants      (wr_grants),
        .grant_idx   (wr_idx),
        .grant_valid (wr_valid)
    );

    assign req_ready = rd_grants | wr_grants;

    // Write port: INIT sweep owns it outside RUN, the write arbiter inside.
    logic             ram_we;
    logic [ADDRW-1:0] ram_waddr, ram_raddr;
    logic [WRENW-1:0] ram_wren;
    logic [DATAW-1:0] ram_wdata, ram_rdata;

    always_comb begin
        ram_we    = 1'b1;
        ram_waddr = init_cnt;
        ram_wren  = '1;
        ram_wdata = INIT_VALUE;
        if (run) begin
            ram_we    = wr_valid;
            ram_waddr = req_addr[int'(wr_idx)*ADDRW +: ADDRW];
            ram_wren  = req_wren[int'(wr_idx)*WRENW +: WRENW];
            ram_wdata = req_data[int'(wr_idx)*DATAW +: DATAW];
        end
    end

    assign ram_raddr = req_addr[int'(rd_idx)*ADDRW +: ADDRW];

    vx_dp_ram #(
        .DATAW (DATAW),
        .SIZE  (SIZE),
        .WRENW (WRENW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wren  (ram_wren),
        .wdata (ram_wdata),
        .re    (rd_valid),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
        end else begin
            rsp_valid <= rd_valid;
            rsp_idx   <= rd_idx;
        end
    end

    assign rsp_data = ram_rdata;

endmodule

// File: tb/tb_vx_dp_ram_sched.sv
module tb_vx_dp_ram_sched;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int SIZE = 64;
    localparam int WE   = 4;
    localparam int AW   = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    req_valid, req_rw, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*WE-1:0] req_wren;
    logic [N*DW-1:0] req_data;
    logic            rsp_valid, init_done;
    logic [1:0]      rsp_idx;
    logic [DW-1:0]   rsp_data;

    always #5 clk = ~clk;

    vx_dp_ram_sched dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wren  (req_wren),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_idx   (rsp_idx),
        .rsp_data  (rsp_data),
        .init_done (init_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: word array, cycles left in the sweep, arbiter pointers.
    logic [DW-1:0] mem_m [SIZE];
    int            init_left;
    int            rd_ptr, wr_ptr;
    logic [N-1:0]  last_ready;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        init_left = SIZE;
        rd_ptr    = 0;
        wr_ptr    = 0;
        for (int i = 0; i < SIZE; i++) mem_m[i] = '0;
    endtask

    // Winner = matching requester at the smallest rotational distance from ptr.
    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] rw,
                                input logic want_rw, input int ptr);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && (rw[i] == want_rw)) begin
                int d;
                d = (i - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // One clock: drive, check ready/init_done, predict, clock, check response.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] rw,
                         input logic [N*AW-1:0] a, input logic [N*WE-1:0] m,
                         input logic [N*DW-1:0] d, input logic f);
        int            wg, rg;
        logic [N-1:0]  er;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] pdata;
        req_valid = v;
        req_rw    = rw;
        req_addr  = a;
        req_wren  = m;
        req_data  = d;
        flush     = f;
        #1;
        check("init_done", init_done, init_left == 0);
        wg = -1;
        rg = -1;
        if (init_left == 0) begin
            wg = pick(v, rw, 1'b1, wr_ptr);
            rg = pick(v, rw, 1'b0, rd_ptr);
        end
        er = '0;
        if (wg >= 0) er[wg] = 1'b1;
        if (rg >= 0) er[rg] = 1'b1;
        last_ready = req_ready;
        check("req_ready", req_ready, er);
        pdata = '0;
        if (wg >= 0) begin
            wa = a[wg*AW +: AW];
            for (int l = 0; l < WE; l++)
                if (m[wg*WE + l]) mem_m[wa][l*8 +: 8] = d[wg*DW + l*8 +: 8];
            wr_ptr = (wg + 1) % N;
        end
        if (rg >= 0) begin
            ra     = a[rg*AW +: AW];
            pdata  = mem_m[ra];
            rd_ptr = (rg + 1) % N;
        end
        if (f) begin
            init_left = SIZE;
            for (int i = 0; i < SIZE; i++) mem_m[i] = '0;
        end else if (init_left > 0) begin
            init_left--;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", rsp_valid, rg >= 0);
        if (rg >= 0) begin
            check("rsp_idx", rsp_idx, rg[1:0]);
            check("rsp_data", rsp_data, pdata);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, '0, 1'b0);
    endtask

    typedef struct {
        logic [N-1:0]  v, rw;
        logic [AW-1:0] a;
        logic [WE-1:0] m;
        logic [DW-1:0] d;
        logic [N-1:0]  exp_ready;
        logic          exp_rv;
        logic [1:0]    exp_idx;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int cnt;

        // Vectors start with rd_ptr=1 (after the addr-63 read), wr_ptr=0.
        tbl[0]  = '{4'b0010, 4'b0010, 6'd5,  4'hF, 32'hDEADBEEF, 4'b0010, 1'b0, 2'd0, 32'h0};
        tbl[1]  = '{4'b0100, 4'b0000, 6'd5,  4'hF, 32'h0,        4'b0100, 1'b1, 2'd2, 32'hDEADBEEF};
        tbl[2]  = '{4'b0001, 4'b0001, 6'd7,  4'hF, 32'hAABBCCDD, 4'b0001, 1'b0, 2'd0, 32'h0};
        tbl[3]  = '{4'b1001, 4'b0001, 6'd7,  4'h3, 32'h11223344, 4'b1001, 1'b1, 2'd3, 32'hAABB3344};
        for (int k = 0; k < 8; k++)
            tbl[4+k] = '{4'b1111, 4'b0000, 6'd5, 4'hF, 32'h0, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 32'hDEADBEEF};
        tbl[12] = '{4'b1000, 4'b1000, 6'd9,  4'hF, 32'hCAFEF00D, 4'b1000, 1'b0, 2'd0, 32'h0};
        tbl[13] = '{4'b0010, 4'b0000, 6'd9,  4'hF, 32'h0,        4'b0010, 1'b1, 2'd1, 32'hCAFEF00D};
        tbl[14] = '{4'b0100, 4'b0100, 6'd9,  4'h0, 32'hFFFFFFFF, 4'b0100, 1'b0, 2'd0, 32'h0};
        tbl[15] = '{4'b0001, 4'b0000, 6'd9,  4'hF, 32'h0,        4'b0001, 1'b1, 2'd0, 32'hCAFEF00D};
        tbl[16] = '{4'b1111, 4'b1111, 6'd10, 4'hF, 32'h12345678, 4'b1000, 1'b0, 2'd0, 32'h0};
        tbl[17] = '{4'b1111, 4'b1111, 6'd10, 4'hF, 32'h12345678, 4'b0001, 1'b0, 2'd0, 32'h0};
        tbl[18] = '{4'b1111, 4'b0101, 6'd10, 4'hF, 32'h12345678, 4'b0110, 1'b1, 2'd1, 32'h12345678};

        // Reset state.
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '1;
        req_rw    = '0;
        req_addr  = '0;
        req_wren  = '0;
        req_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_init_done", init_done, 1'b0);
        check("reset_ready", req_ready, 4'b0000);
        reset     = 1'b0;
        req_valid = '0;
        model_reset();

        // Sweep after reset release must take exactly SIZE cycles.
        cnt = 0;
        while (!init_done && cnt < 200) begin
            idle(1);
            cnt++;
        end
        check("init_sweep_cycles", cnt, SIZE);
        cycle(4'b0001, 4'b0000, {4{6'd63}}, '0, '0, 1'b0);
        check("read_addr63", rsp_data, 32'h0);

        // Table-driven vectors.
        for (int k = 0; k < 19; k++) begin
            cycle(tbl[k].v, tbl[k].rw, {4{tbl[k].a}}, {4{tbl[k].m}}, {4{tbl[k].d}}, 1'b0);
            check($sformatf("tbl%0d_ready", k), last_ready, tbl[k].exp_ready);
            check($sformatf("tbl%0d_rsp_valid", k), rsp_valid, tbl[k].exp_rv);
            if (tbl[k].exp_rv) begin
                check($sformatf("tbl%0d_rsp_idx", k), rsp_idx, tbl[k].exp_idx);
                check($sformatf("tbl%0d_rsp_data", k), rsp_data, tbl[k].exp_data);
            end
        end

        // Flush in RUN with a read in the flush cycle (pre-flush data).
        cycle(4'b0001, 4'b0001, '0, {4{4'hF}}, {4{32'h5}}, 1'b0);
        cycle(4'b0010, 4'b0000, '0, '0, '0, 1'b1);
        check("flush_cycle_read", rsp_data, 32'h5);
        check("flush_next_init_done", init_done, 1'b0);
        idle(SIZE);
        check("flush_sweep_done", init_done, 1'b1);
        cycle(4'b0001, 4'b0000, '0, '0, '0, 1'b0);
        check("flush_addr0", rsp_data, 32'h0);

        // Flush during INIT restarts the sweep.
        cycle('0, '0, '0, '0, '0, 1'b1);
        idle(20);
        cycle('0, '0, '0, '0, '0, 1'b1);
        idle(SIZE - 1);
        check("reflush_still_init", init_done, 1'b0);
        idle(1);
        check("reflush_done", init_done, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), 4'($urandom), 24'($urandom) & 24'h1C71C7, 16'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 59) == 0);
        end

        // Reset while a read is being granted.
        cnt = 0;
        while (!init_done && cnt < 200) begin
            idle(1);
            cnt++;
        end
        check("run_before_reset", init_done, 1'b1);
        req_valid = 4'b0001;
        req_rw    = 4'b0000;
        req_addr  = '0;
        flush     = 1'b0;
        #1;
        check("pre_reset_grant", req_ready, 4'b0001);
        reset = 1'b1;
        #1;
        check("reset_aborts_rsp", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold_rsp", rsp_valid, 1'b0);
        reset     = 1'b0;
        req_valid = '0;
        model_reset();
        cnt = 0;
        while (!init_done && cnt < 200) begin
            idle(1);
            cnt++;
        end
        check("reinit_sweep_cycles", cnt, SIZE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
